// File: rtl/mdu_issue_ctrl.sv
// Issue controller between E-stage pipeline control and the multiply/divide unit.
// Starts mult/div ops, tracks their latency, stalls colliding HI/LO ops and counts stall cycles.
module mdu_issue_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic             flush,
    output logic             req_ready,
    output logic             stall,
    output logic             mdu_start,
    output logic [3:0]       mdu_op,
    output logic [31:0]      mdu_a,
    output logic [31:0]      mdu_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned LW   = $clog2(MAXC + 1);

    localparam logic [LW-1:0] MUL_LOAD = LW'(MUL_CYCLES - 1);
    localparam logic [LW-1:0] DIV_LOAD = LW'(DIV_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0]       r_state;
    logic [LW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_hit;
    logic w_idle;
    logic w_accept;
    logic w_is_mul;
    logic w_is_div;
    logic w_last;

    always_comb begin
        w_hit    = req_valid && (req_op >= 4'd1) && (req_op <= 4'd9) && !flush;
        w_idle   = (r_state == S_IDLE);
        w_is_mul = (req_op == 4'd1) || (req_op == 4'd2);
        w_is_div = (req_op == 4'd3) || (req_op == 4'd4);
        w_last   = !w_idle && (r_cnt == '0);
        // Combinational outputs are forced low while reset is held.
        w_accept = reset && w_hit && w_idle;
    end

    always_comb begin
        req_ready = w_accept;
        stall     = reset && w_hit && !w_idle;
        mdu_start = w_accept && (w_is_mul || w_is_div);
        mdu_op    = w_accept ? req_op : 4'd0;
        mdu_a     = reset ? req_a : '0;
        mdu_b     = reset ? req_b : '0;
        busy      = !w_idle;
        done      = w_last;
        stall_cnt = r_stall_cnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_state <= S_MUL;
                        r_cnt   <= MUL_LOAD;
                    end else if (w_accept && w_is_div) begin
                        r_state <= S_DIV;
                        r_cnt   <= DIV_LOAD;
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - LW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
